bus_arbiter: RTL and testbench

Two-master arbiter in front of the system bridge. It shares the single processor-side bridge port between master 0 (CPU memory stage) and master 1 (DMA engine), using round-robin priority. It latches each granted transaction and drives it onto the bridge until the addressed device signals ready or a timeout expires. It then returns the read data and a one-cycle completion pulse to the winner.

---
 rtl/bus_arbiter_pkg.sv | 15 +
 rtl/bus_arbiter_rr_pick2.sv | 18 +
 rtl/bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the two-master bus arbiter.
// Word width and FSM state encodings.
package bus_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin picker.
// On a tie the master that did not win last time is chosen.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = req[1];
        if (&req) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the bridge port between CPU (m0) and DMA (m1).
// Latches the granted request and holds it on the bridge until ready or timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  word_t       m0_addr,
    input  word_t       m1_addr,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [3:0]  m0_be,
    input  logic [3:0]  m1_be,
    input  word_t       m0_wd,
    input  word_t       m1_wd,
    input  word_t       m0_pc,
    input  word_t       m1_pc,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output word_t       m0_rd,
    output word_t       m1_rd,
    output word_t       PrAddr,
    output logic [3:0]  PrBE,
    output word_t       PrWD,
    output word_t       PrPC,
    output logic        PrWE,
    input  word_t       PrRD,
    input  logic        bus_ready
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;
    word_t      addr_q, addr_d;
    logic       we_q, we_d;
    logic [3:0] be_q, be_d;
    word_t      wd_q, wd_d;
    word_t      pc_q, pc_d;
    logic [7:0] cnt_q, cnt_d;
    word_t      rdata_q, rdata_d;
    logic       err_q, err_d;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req    ({m1_req, m0_req}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wd_q    <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wd_d    = wd_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    addr_d  = pick_winner ? m1_addr : m0_addr;
                    we_d    = pick_winner ? m1_we   : m0_we;
                    be_d    = pick_winner ? m1_be   : m0_be;
                    wd_d    = pick_winner ? m1_wd   : m0_wd;
                    pc_d    = pick_winner ? m1_pc   : m0_pc;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (bus_ready) begin
                    rdata_d = we_q ? '0 : PrRD;
                    err_d   = 1'b0;
                    state_d = ARB_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ARB_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ARB_DONE: begin
                last_d  = owner_q;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    logic busy;
    logic done;
    assign busy = (state_q == ARB_BUSY);
    assign done = (state_q == ARB_DONE);

    // Write strobe is gated by ready so a stalled write commits exactly once.
    assign PrAddr = busy ? addr_q : '0;
    assign PrBE   = busy ? be_q   : '0;
    assign PrWD   = busy ? wd_q   : '0;
    assign PrPC   = busy ? pc_q   : '0;
    assign PrWE   = busy & we_q & bus_ready;

    assign m0_gnt  = (busy | done) & ~owner_q;
    assign m1_gnt  = (busy | done) &  owner_q;
    assign m0_done = done & ~owner_q;
    assign m1_done = done &  owner_q;
    assign m0_err  = m0_done & err_q;
    assign m1_err  = m1_done & err_q;
    assign m0_rd   = m0_done ? rdata_q : '0;
    assign m1_rd   = m1_done ? rdata_q : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT = 4).
// Inputs change 1 ns after posedge; outputs are sampled at negedge.
module tb_bus_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_we, m1_we;
    logic [3:0]  m0_be, m1_be;
    logic [31:0] m0_wd, m1_wd;
    logic [31:0] m0_pc, m1_pc;
    logic        m0_gnt, m1_gnt;
    logic        m0_done, m1_done;
    logic        m0_err, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic [31:0] PrAddr;
    logic [3:0]  PrBE;
    logic [31:0] PrWD, PrPC;
    logic        PrWE;
    logic [31:0] PrRD;
    logic        bus_ready;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_be(m0_be), .m1_be(m1_be),
        .m0_wd(m0_wd), .m1_wd(m1_wd),
        .m0_pc(m0_pc), .m1_pc(m1_pc),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
        .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err),
        .m0_rd(m0_rd), .m1_rd(m1_rd),
        .PrAddr(PrAddr), .PrBE(PrBE), .PrWD(PrWD), .PrPC(PrPC),
        .PrWE(PrWE), .PrRD(PrRD), .bus_ready(bus_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0;
        m0_addr = 0; m1_addr = 0;
        m0_we = 0; m1_we = 0;
        m0_be = 0; m1_be = 0;
        m0_wd = 0; m1_wd = 0;
        m0_pc = 0; m1_pc = 0;
        PrRD = 0; bus_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 0;
        repeat (2) tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        bus_ready = 1;
        PrRD = 32'h5555_AAAA;
        for (int c = 0; c < 3; c++) begin
            smp();
            checks++;
            if ({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, PrWE} !== 7'b0
                || m0_rd !== 0 || m1_rd !== 0 || PrAddr !== 0 || PrBE !== 0
                || PrWD !== 0 || PrPC !== 0) begin
                errors++;
                $display("FAIL reset_idle c%0d: gnt=%b%b done=%b%b we=%b addr=%h want all 0",
                         c, m0_gnt, m1_gnt, m0_done, m1_done, PrWE, PrAddr);
            end
            tick();
        end
        bus_ready = 0;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_req = 1; m0_addr = 32'h0000_1000; m0_we = 0; m0_be = 4'hF;
        m0_pc = 32'h0000_0400;
        smp();
        checks++;
        if (m0_gnt !== 0) begin
            errors++; $display("FAIL read_c0_gnt: got %b want 0", m0_gnt);
        end
        tick();
        bus_ready = 1; PrRD = 32'hDEAD_BEEF;
        smp();
        checks++;
        if (m0_gnt !== 1 || PrAddr !== 32'h1000 || PrWE !== 0
            || PrPC !== 32'h400 || PrBE !== 4'hF) begin
            errors++;
            $display("FAIL read_c1_bus: gnt=%b addr=%h we=%b pc=%h be=%h want 1 1000 0 400 f",
                     m0_gnt, PrAddr, PrWE, PrPC, PrBE);
        end
        tick();
        bus_ready = 0; PrRD = 0;
        smp();
        checks++;
        if (m0_done !== 1 || m0_rd !== 32'hDEAD_BEEF || m0_err !== 0
            || m1_done !== 0 || PrAddr !== 0) begin
            errors++;
            $display("FAIL read_c2_done: done=%b rd=%h err=%b addr=%h want 1 deadbeef 0 0",
                     m0_done, m0_rd, m0_err, PrAddr);
        end
        tick();
        m0_req = 0;
        smp();
        checks++;
        if (m0_done !== 0 || m0_gnt !== 0) begin
            errors++; $display("FAIL read_c3_idle: done=%b gnt=%b want 0 0", m0_done, m0_gnt);
        end
    endtask

    task automatic test_fairness();
        logic exp0, exp1;
        do_reset();
        m0_req = 1; m1_req = 1; bus_ready = 1;
        PrRD = 32'hCAFE_0001;
        m0_addr = 32'hA0; m1_addr = 32'hB0;
        for (int c = 0; c < 12; c++) begin
            exp0 = (c == 2) || (c == 8);
            exp1 = (c == 5) || (c == 11);
            smp();
            checks++;
            if (m0_done !== exp0 || m1_done !== exp1) begin
                errors++;
                $display("FAIL fair_c%0d: done=%b%b want %b%b", c, m0_done, m1_done, exp0, exp1);
            end
            if (c == 1 || c == 4) begin
                checks++;
                if (PrAddr !== (c == 1 ? 32'hA0 : 32'hB0)) begin
                    errors++; $display("FAIL fair_addr_c%0d: got %h", c, PrAddr);
                end
            end
            if (c == 5) begin
                checks++;
                if (m1_rd !== 32'hCAFE_0001 || m0_rd !== 0) begin
                    errors++; $display("FAIL fair_rd: m1_rd=%h m0_rd=%h want cafe0001 0", m1_rd, m0_rd);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_write_wait();
        int we_cnt;
        we_cnt = 0;
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_7F00;
        m1_wd = 32'h1234; m1_be = 4'hF;
        for (int c = 0; c < 7; c++) begin
            bus_ready = (c == 4);
            if (c == 6) m1_req = 0;
            smp();
            if (PrWE === 1'b1) we_cnt++;
            if (c == 4) begin
                checks++;
                if (PrWE !== 1 || PrAddr !== 32'h7F00 || PrWD !== 32'h1234 || PrBE !== 4'hF) begin
                    errors++;
                    $display("FAIL wr_c4: we=%b addr=%h wd=%h be=%h want 1 7f00 1234 f",
                             PrWE, PrAddr, PrWD, PrBE);
                end
            end
            checks++;
            if (m1_done !== (c == 5)) begin
                errors++; $display("FAIL wr_done_c%0d: got %b want %b", c, m1_done, c == 5);
            end
            if (c == 5) begin
                checks++;
                if (m1_err !== 0 || m1_rd !== 0) begin
                    errors++; $display("FAIL wr_result: err=%b rd=%h want 0 0", m1_err, m1_rd);
                end
            end
            tick();
        end
        checks++;
        if (we_cnt != 1) begin
            errors++; $display("FAIL wr_strobe_count: got %0d want 1", we_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int we_cnt;
        we_cnt = 0;
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h2000;
        PrRD = 32'hFFFF_FFFF;
        for (int c = 0; c < 7; c++) begin
            if (c == 6) m0_req = 0;
            smp();
            if (PrWE === 1'b1) we_cnt++;
            checks++;
            if (m0_done !== (c == 5) || m0_gnt !== (c >= 1 && c <= 5)) begin
                errors++;
                $display("FAIL to_c%0d: done=%b gnt=%b", c, m0_done, m0_gnt);
            end
            if (c == 5) begin
                checks++;
                if (m0_err !== 1 || m0_rd !== 0) begin
                    errors++; $display("FAIL to_result: err=%b rd=%h want 1 0", m0_err, m0_rd);
                end
            end
            tick();
        end
        checks++;
        if (we_cnt != 0) begin
            errors++; $display("FAIL to_strobe: got %0d want 0", we_cnt);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h300; m1_wd = 32'h77;
        tick();
        smp();
        checks++;
        if (m1_gnt !== 1 || PrAddr !== 32'h300) begin
            errors++; $display("FAIL rst_mid_busy: gnt=%b addr=%h want 1 300", m1_gnt, PrAddr);
        end
        tick();
        reset_n = 0;
        bus_ready = 1;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_done, m1_done, PrWE} !== 5'b0
            || PrAddr !== 0 || PrWD !== 0 || m1_rd !== 0) begin
            errors++;
            $display("FAIL rst_mid_async: gnt=%b%b done=%b%b we=%b addr=%h want all 0",
                     m0_gnt, m1_gnt, m0_done, m1_done, PrWE, PrAddr);
        end
        #1;
        reset_n = 1;
        m0_req = 1; m1_req = 1; bus_ready = 0;
        smp();
        checks++;
        if (m0_gnt !== 0 || m1_gnt !== 0 || PrWE !== 0) begin
            errors++; $display("FAIL rst_mid_idle: gnt=%b%b we=%b", m0_gnt, m1_gnt, PrWE);
        end
        tick();
        smp();
        checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0) begin
            errors++; $display("FAIL rst_mid_tie: gnt=%b%b want 10", m0_gnt, m1_gnt);
        end
        idle_inputs();
    endtask

    task automatic test_latching();
        do_reset();
        m0_req = 1; m0_addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            if (c == 2) m0_addr = 32'h20;
            bus_ready = (c == 3);
            if (c == 5) m0_req = 0;
            smp();
            if (c >= 1 && c <= 3) begin
                checks++;
                if (PrAddr !== 32'h10) begin
                    errors++; $display("FAIL latch_c%0d: got %h want 10", c, PrAddr);
                end
            end
            if (c == 4) begin
                checks++;
                if (m0_done !== 1 || PrAddr !== 0) begin
                    errors++; $display("FAIL latch_done: done=%b addr=%h want 1 0", m0_done, PrAddr);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_fairness();
        test_write_wait();
        test_timeout();
        test_reset_mid();
        test_latching();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
